// File: rtl/axi_master_bridge_pkg.sv
// Shared encodings, FSM state types and the byte-select to AXI size helper
// for the cache-side to AXI4 master bridge.
package axi_master_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } w_state_e;

    // Bursts are always word-wide; single beats narrow to the selected lanes.
    function automatic logic [2:0] sel_to_size(input logic [3:0] sel, input logic [3:0] len);
        logic [2:0] size;
        if (len != 4'd0) begin
            size = SIZE_WORD;
        end else begin
            case (sel)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
                4'b0011, 4'b1100:                   size = SIZE_HALF;
                default:                            size = SIZE_WORD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_master_bridge_if.sv
// AXI4 AR/R/AW/W/B channel bundle between the bridge (master) and the
// interconnect or slave model (slave).
interface axi_master_bridge_if #(
    parameter int ID_W = 4
);

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_master_bridge_size_decode.sv
// Combinational byte-select + length to AXI transfer size; one instance per
// bridge path.
module axi_size_decode
    import axi_master_bridge_pkg::*;
(
    input  logic [3:0] sel_i,
    input  logic [3:0] len_i,
    output logic [2:0] size_o
);

    assign size_o = sel_to_size(sel_i, len_i);

endmodule

// File: rtl/axi_master_bridge.sv
// Cache-side simple bus to AXI4 master bridge with independent read and write FSMs.
// Optional sticky response/ID error flag is enabled by defining AXI_BRIDGE_ERR_EN.
module axi_master_bridge
    import axi_master_bridge_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int RD_ID = 0,
    parameter int WR_ID = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ce_i,

    input  logic                ren_i,
    input  logic [31:0]         raddr_i,
    input  logic [3:0]          rlen_i,
    input  logic [3:0]          rsel_i,
    output logic [31:0]         rdata_o,
    output logic                rdata_valid_o,

    input  logic                wen_i,
    input  logic [31:0]         waddr_i,
    input  logic [3:0]          wlen_i,
    input  logic [3:0]          wsel_i,
    input  logic [31:0]         wdata_i,
    output logic                wdata_resp_o,

    output logic                bus_err_o,

    axi_master_bridge_if.master axi
);

    localparam logic [ID_W-1:0] RD_ID_V = ID_W'(RD_ID);
    localparam logic [ID_W-1:0] WR_ID_V = ID_W'(WR_ID);

    r_state_e    r_state_q, r_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [2:0]  rsize_dec;
    logic        r_beat;

    w_state_e    w_state_q, w_state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [3:0]  awlen_q, awlen_d;
    logic [2:0]  awsize_q, awsize_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [2:0]  wsize_dec;
    logic        w_last;
    logic        w_beat;
    logic        b_beat;

    axi_size_decode u_rsize (
        .sel_i  (rsel_i),
        .len_i  (rlen_i),
        .size_o (rsize_dec)
    );

    axi_size_decode u_wsize (
        .sel_i  (wsel_i),
        .len_i  (wlen_i),
        .size_o (wsize_dec)
    );

    assign r_beat = axi.rvalid & rready_q;

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        case (r_state_q)
            R_IDLE: begin
                if (ce_i & ren_i) begin
                    r_state_d = R_ADDR;
                    araddr_d  = raddr_i;
                    arlen_d   = rlen_i;
                    arsize_d  = rsize_dec;
                    arvalid_d = 1'b1;
                end
            end
            R_ADDR: begin
                if (axi.arready) begin
                    r_state_d = R_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            R_DATA: begin
                if (r_beat & axi.rlast) begin
                    r_state_d = R_IDLE;
                    rready_d  = 1'b0;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    assign axi.arid    = RD_ID_V;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = {4'b0000, arlen_q};
    assign axi.arsize  = arsize_q;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign rdata_o       = axi.rdata;
    assign rdata_valid_o = r_beat;

    // wlast is qualified by wvalid so the idle bus never shows a stray last flag.
    assign w_last = wvalid_q & (beat_cnt_q == awlen_q);
    assign w_beat = wvalid_q & axi.wready;
    assign b_beat = bready_q & axi.bvalid;

    always_comb begin
        w_state_d  = w_state_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        beat_cnt_d = beat_cnt_q;
        case (w_state_q)
            W_IDLE: begin
                if (ce_i & wen_i) begin
                    w_state_d = W_ADDR;
                    awaddr_d  = waddr_i;
                    awlen_d   = wlen_i;
                    awsize_d  = wsize_dec;
                    awvalid_d = 1'b1;
                end
            end
            W_ADDR: begin
                if (axi.awready) begin
                    w_state_d  = W_DATA;
                    awvalid_d  = 1'b0;
                    wvalid_d   = 1'b1;
                    beat_cnt_d = 4'd0;
                end
            end
            W_DATA: begin
                if (w_beat) begin
                    if (w_last) begin
                        w_state_d  = W_RESP;
                        wvalid_d   = 1'b0;
                        bready_d   = 1'b1;
                        beat_cnt_d = 4'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (axi.bvalid) begin
                    w_state_d = W_IDLE;
                    bready_d  = 1'b0;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            awsize_q   <= awsize_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign axi.awid    = WR_ID_V;
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = {4'b0000, awlen_q};
    assign axi.awsize  = awsize_q;
    assign axi.awburst = BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = WR_ID_V;
    assign axi.wdata   = wdata_i;
    assign axi.wstrb   = wsel_i;
    assign axi.wlast   = w_last;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // The final beat of a burst reports progress on B, not on its W handshake.
    assign wdata_resp_o = (w_beat & ~w_last) | b_beat;

`ifdef AXI_BRIDGE_ERR_EN
    logic bus_err_q, bus_err_d;
    logic r_err, b_err;

    assign r_err     = r_beat & ((axi.rresp != RESP_OKAY) | (axi.rid != RD_ID_V));
    assign b_err     = b_beat & ((axi.bresp != RESP_OKAY) | (axi.bid != WR_ID_V));
    assign bus_err_d = bus_err_q | r_err | b_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    logic unused_err_inputs;

    assign unused_err_inputs = ^{axi.rresp, axi.rid, axi.bresp, axi.bid};
    assign bus_err_o         = 1'b0;
`endif

endmodule
